data_memory: RTL and testbench

//   Word-organised data RAM for the MEM stage of the 5-stage in-order RV32 core.

---
 rtl/core_pkg.sv | 20 ++
 rtl/data_memory_if.sv | 20 ++
 rtl/dmem_load_align.sv | 25 ++
 rtl/data_memory.sv | 53 +++++
 tb/tb_data_memory.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared core constants: data memory default depth and the byte-lane mask encodings
// that the store unit emits and the load aligner decodes.
package core_pkg;

   localparam int DMEM_DEPTH = 1024;

   localparam logic [3:0] BE_BYTE0 = 4'b0001;
   localparam logic [3:0] BE_BYTE1 = 4'b0010;
   localparam logic [3:0] BE_BYTE2 = 4'b0100;
   localparam logic [3:0] BE_BYTE3 = 4'b1000;
   localparam logic [3:0] BE_HALF0 = 4'b0011;
   localparam logic [3:0] BE_HALF1 = 4'b1100;
   localparam logic [3:0] BE_WORD  = 4'b1111;

   // Expands a 4-bit lane mask into a 32-bit bit mask.
   function automatic logic [31:0] lane_mask(input logic [3:0] be);
      return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
   endfunction

endpackage

// File: rtl/data_memory_if.sv
// MEM-stage data memory bus: the core drives the request side (master),
// the RAM returns the combinational load result (slave).
interface data_memory_if;
   logic        mem_read;
   logic        mem_write;
   logic [3:0]  byte_en;
   logic [31:0] addr;
   logic [31:0] write_data;
   logic [31:0] read_data;

   modport master (
      output mem_read, mem_write, byte_en, addr, write_data,
      input  read_data
   );

   modport slave (
      input  mem_read, mem_write, byte_en, addr, write_data,
      output read_data
   );
endinterface

// File: rtl/dmem_load_align.sv
// Load aligner: moves the byte_en-selected field of a word down to bit 0 and
// sign-extends it; irregular lane masks just zero the unselected lanes.
module dmem_load_align
   import core_pkg::*;
(
   input  logic [31:0] i_word,
   input  logic [3:0]  i_byte_en,
   output logic [31:0] o_data
);

   always_comb begin
      o_data = i_word & lane_mask(i_byte_en);
      case (i_byte_en)
         BE_BYTE0: o_data = {{24{i_word[7]}},  i_word[7:0]};
         BE_BYTE1: o_data = {{24{i_word[15]}}, i_word[15:8]};
         BE_BYTE2: o_data = {{24{i_word[23]}}, i_word[23:16]};
         BE_BYTE3: o_data = {{24{i_word[31]}}, i_word[31:24]};
         BE_HALF0: o_data = {{16{i_word[15]}}, i_word[15:0]};
         BE_HALF1: o_data = {{16{i_word[31]}}, i_word[31:16]};
         BE_WORD:  o_data = i_word;
         default:  ;
      endcase
   end

endmodule

// File: rtl/data_memory.sv
// Word-organised data RAM for the MEM stage: byte-lane writes on the rising edge,
// combinational sign-extending reads, whole array cleared by the asynchronous reset.
module data_memory
   import core_pkg::*;
#(
   parameter int DEPTH    = DMEM_DEPTH,
   parameter int ADDR_LSB = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   data_memory_if.slave  bus
);

   localparam int IDX_W = $clog2(DEPTH);

   logic [31:0]      r_mem [DEPTH];
   logic [IDX_W-1:0] w_idx;
   logic [31:0]      w_word;
   logic [31:0]      w_aligned;
   logic             w_unused_addr;

   // Upper bits alias onto the array; low bits are superseded by byte_en.
   assign w_idx         = bus.addr[ADDR_LSB+IDX_W-1:ADDR_LSB];
   assign w_unused_addr = ^{bus.addr[31:ADDR_LSB+IDX_W], bus.addr[ADDR_LSB-1:0]};

   // NOTE: every word sits in the reset branch because the core relies on a zeroed
   // data memory after reset; this forces a flop array, not an inferred SRAM macro.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (bus.mem_write) begin
         for (int b = 0; b < 4; b++) begin
            if (bus.byte_en[b]) begin
               r_mem[w_idx][8*b +: 8] <= bus.write_data[8*b +: 8];
            end
         end
      end
   end

   assign w_word = r_mem[w_idx];

   dmem_load_align u_load_align (
      .i_word    (w_word),
      .i_byte_en (bus.byte_en),
      .o_data    (w_aligned)
   );

   // No write bypass: a read in the write cycle sees the old word until the edge.
   assign bus.read_data = (rst_n && bus.mem_read) ? w_aligned : 32'h0;

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: word/byte/half accesses, sign extension,
// lane merging, read-during-write, reset clearing and address wrap.
module tb_data_memory;

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;

   data_memory_if bus ();

   data_memory dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      @(negedge clk);
      bus.addr       = a;
      bus.write_data = d;
      bus.byte_en    = be;
      bus.mem_write  = 1'b1;
      bus.mem_read   = 1'b0;
      @(posedge clk);
      #1;
      bus.mem_write  = 1'b0;
   endtask

   task automatic do_read(input logic [31:0] a, input logic [3:0] be, output logic [31:0] d);
      bus.addr      = a;
      bus.byte_en   = be;
      bus.mem_write = 1'b0;
      bus.mem_read  = 1'b1;
      #1;
      d = bus.read_data;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      bus.addr       = 32'h0;
      bus.byte_en    = 4'b1111;
      bus.write_data = 32'h0;
      bus.mem_write  = 1'b0;
      bus.mem_read   = 1'b1;
      rst_n          = 1'b0;
      #12;
      d = bus.read_data;
      checks++;
      if (d !== 32'h0) begin
         errors++;
         $display("FAIL reset_rd: got %h expected %h", d, 32'h0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      do_read(32'h0, 4'b1111, d);
      checks++;
      if (d !== 32'h0) begin
         errors++;
         $display("FAIL reset_word0: got %h expected %h", d, 32'h0);
      end
   endtask

   task automatic test_word();
      logic [31:0] d;
      do_write(32'h0, 32'hDEADBEEF, 4'b1111);
      do_read(32'h0, 4'b1111, d);
      checks++;
      if (d !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL word_rd: got %h expected %h", d, 32'hDEADBEEF);
      end
      do_read(32'h3, 4'b1111, d);
      checks++;
      if (d !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL word_low_addr_ignored: got %h expected %h", d, 32'hDEADBEEF);
      end
      bus.mem_read = 1'b0;
      #1;
      checks++;
      if (bus.read_data !== 32'h0) begin
         errors++;
         $display("FAIL read_gate: got %h expected %h", bus.read_data, 32'h0);
      end
   endtask

   task automatic test_byte();
      logic [31:0] d;
      do_write(32'h4, 32'h000000FF, 4'b0001);
      do_read(32'h4, 4'b1111, d);
      checks++;
      if (d !== 32'h000000FF) begin
         errors++;
         $display("FAIL byte_word_rd: got %h expected %h", d, 32'h000000FF);
      end
      do_read(32'h4, 4'b0001, d);
      checks++;
      if (d !== 32'hFFFFFFFF) begin
         errors++;
         $display("FAIL byte_sext: got %h expected %h", d, 32'hFFFFFFFF);
      end
      do_read(32'h0, 4'b0010, d);
      checks++;
      if (d !== 32'hFFFFFFBE) begin
         errors++;
         $display("FAIL byte1_rd: got %h expected %h", d, 32'hFFFFFFBE);
      end
   endtask

   task automatic test_half();
      logic [31:0] d;
      do_write(32'h8, 32'h0000ABCD, 4'b0011);
      do_read(32'h8, 4'b1111, d);
      checks++;
      if (d !== 32'h0000ABCD) begin
         errors++;
         $display("FAIL half_word_rd: got %h expected %h", d, 32'h0000ABCD);
      end
      do_read(32'h8, 4'b0011, d);
      checks++;
      if (d !== 32'hFFFFABCD) begin
         errors++;
         $display("FAIL half_sext: got %h expected %h", d, 32'hFFFFABCD);
      end
      do_read(32'h0, 4'b1100, d);
      checks++;
      if (d !== 32'hFFFFDEAD) begin
         errors++;
         $display("FAIL half1_rd: got %h expected %h", d, 32'hFFFFDEAD);
      end
   endtask

   task automatic test_sign_ext();
      logic [31:0] d;
      do_write(32'h10, 32'h00000080, 4'b0001);
      do_read(32'h10, 4'b0001, d);
      checks++;
      if (d !== 32'hFFFFFF80) begin
         errors++;
         $display("FAIL sext_neg_byte: got %h expected %h", d, 32'hFFFFFF80);
      end
      do_write(32'h14, 32'h007F0000, 4'b0100);
      do_read(32'h14, 4'b0100, d);
      checks++;
      if (d !== 32'h0000007F) begin
         errors++;
         $display("FAIL sext_pos_byte2: got %h expected %h", d, 32'h0000007F);
      end
   endtask

   task automatic test_lane_merge();
      logic [31:0] d;
      do_write(32'h20, 32'h11223344, 4'b1111);
      do_write(32'h20, 32'hAA000000, 4'b1000);
      do_read(32'h20, 4'b1111, d);
      checks++;
      if (d !== 32'hAA223344) begin
         errors++;
         $display("FAIL merge_rd: got %h expected %h", d, 32'hAA223344);
      end
      do_read(32'h20, 4'b1000, d);
      checks++;
      if (d !== 32'hFFFFFFAA) begin
         errors++;
         $display("FAIL merge_byte3: got %h expected %h", d, 32'hFFFFFFAA);
      end
      do_write(32'h20, 32'h55555555, 4'b0000);
      do_read(32'h20, 4'b1111, d);
      checks++;
      if (d !== 32'hAA223344) begin
         errors++;
         $display("FAIL be_zero_write: got %h expected %h", d, 32'hAA223344);
      end
   endtask

   task automatic test_irregular_mask();
      logic [31:0] d;
      do_read(32'h0, 4'b0101, d);
      checks++;
      if (d !== 32'h00AD00EF) begin
         errors++;
         $display("FAIL mask_0101: got %h expected %h", d, 32'h00AD00EF);
      end
      do_read(32'h0, 4'b0111, d);
      checks++;
      if (d !== 32'h00ADBEEF) begin
         errors++;
         $display("FAIL mask_0111: got %h expected %h", d, 32'h00ADBEEF);
      end
      do_read(32'h0, 4'b0000, d);
      checks++;
      if (d !== 32'h0) begin
         errors++;
         $display("FAIL mask_0000: got %h expected %h", d, 32'h0);
      end
   endtask

   task automatic test_read_during_write();
      logic [31:0] d;
      do_write(32'h30, 32'h12345678, 4'b1111);
      @(negedge clk);
      bus.addr       = 32'h30;
      bus.byte_en    = 4'b1111;
      bus.write_data = 32'hCAFEF00D;
      bus.mem_read   = 1'b1;
      bus.mem_write  = 1'b1;
      #1;
      d = bus.read_data;
      checks++;
      if (d !== 32'h12345678) begin
         errors++;
         $display("FAIL rdw_before_edge: got %h expected %h", d, 32'h12345678);
      end
      @(posedge clk);
      #1;
      d = bus.read_data;
      bus.mem_write = 1'b0;
      checks++;
      if (d !== 32'hCAFEF00D) begin
         errors++;
         $display("FAIL rdw_after_edge: got %h expected %h", d, 32'hCAFEF00D);
      end
   endtask

   task automatic test_reset_wrap();
      logic [31:0] d;
      logic [31:0] addrs [5];
      addrs = '{32'h0, 32'h4, 32'h8, 32'h20, 32'h30};
      @(negedge clk);
      #2;
      bus.addr     = 32'h20;
      bus.byte_en  = 4'b1111;
      bus.mem_read = 1'b1;
      rst_n        = 1'b0;
      #1;
      checks++;
      if (bus.read_data !== 32'h0) begin
         errors++;
         $display("FAIL reset_mid_rd: got %h expected %h", bus.read_data, 32'h0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         do_read(addrs[i], 4'b1111, d);
         checks++;
         if (d !== 32'h0) begin
            errors++;
            $display("FAIL reset_cleared[%h]: got %h expected %h", addrs[i], d, 32'h0);
         end
      end
      do_write(32'h1000, 32'h5A5A5A5A, 4'b1111);
      do_read(32'h0, 4'b1111, d);
      checks++;
      if (d !== 32'h5A5A5A5A) begin
         errors++;
         $display("FAIL wrap_alias: got %h expected %h", d, 32'h5A5A5A5A);
      end
      do_read(32'hFFFF_1000, 4'b0001, d);
      checks++;
      if (d !== 32'h0000005A) begin
         errors++;
         $display("FAIL wrap_upper_bits: got %h expected %h", d, 32'h0000005A);
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_word();
      test_byte();
      test_half();
      test_sign_ext();
      test_lane_merge();
      test_irregular_mask();
      test_read_during_write();
      test_reset_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
